// File: rtl/uart_tx_arb_pkg.sv
// uart_tx_arb_pkg: one-hot FSM states and shared widths for the UART TX arbiter
package uart_tx_arb_pkg;
    localparam int STATE_BITS = 4;
    typedef logic [STATE_BITS-1:0] state_t;
    localparam state_t S_IDLE      = 4'b0001;
    localparam state_t S_START     = 4'b0010;
    localparam state_t S_WAIT_ACT  = 4'b0100;
    localparam state_t S_WAIT_DONE = 4'b1000;
    localparam int OWNER_BITS = 3;
    localparam int TO_BITS = 8;
endpackage

// File: rtl/uart_tx_arbiter_rr.sv
// rr_arbiter_comb: combinational round-robin pick, first requester at/after ptr with wrap
module rr_arbiter_comb
    import uart_tx_arb_pkg::*;
#(
    parameter int NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0]    req,
    input  logic [OWNER_BITS-1:0] ptr,
    output logic [NUM_REQ-1:0]    grant,
    output logic [OWNER_BITS-1:0] idx
);
    // lowest requester overall is the wrap fallback; lowest at/after ptr overrides it
    always_comb begin
        idx = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--)
            if (req[i]) idx = OWNER_BITS'(i);
        for (int i = NUM_REQ - 1; i >= 0; i--)
            if (req[i] && i >= int'(ptr)) idx = OWNER_BITS'(i);
        grant = |req ? NUM_REQ'(1) << idx : '0;
    end
endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: shares one UART TX serializer among NUM_REQ byte sources (round-robin).
// Optional burst lock enabled by defining UART_TX_ARB_LOCK_EN.
module uart_tx_arbiter
    import uart_tx_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ACTIVE_TIMEOUT = 15
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  sync_reset,
    input  logic [NUM_REQ-1:0]    req,
    input  logic [8*NUM_REQ-1:0]  req_data,
    input  logic [NUM_REQ-1:0]    req_lock,
    output logic [NUM_REQ-1:0]    ack,
    output logic [OWNER_BITS-1:0] owner,
    output logic                  busy,
    output logic                  timeout_err,
    output logic                  uart_start_TX,
    output logic [7:0]            uart_SBUF,
    input  logic                  uart_tx_active
);
    state_t state, state_nxt;
    logic [OWNER_BITS-1:0] ptr, ptr_nxt, owner_nxt, owner_inc, pick_idx;
    logic [NUM_REQ-1:0] pick_grant, ack_nxt, owner_hot;
    logic [TO_BITS-1:0] cnt, cnt_nxt;
    logic [7:0] pick_byte, sbuf_nxt;
    logic grant_ok, to_hit, done, lock_hold, busy_nxt, start_nxt, terr_nxt;

    rr_arbiter_comb #(.NUM_REQ(NUM_REQ)) u_rr (
        .req   (req),
        .ptr   (ptr),
        .grant (pick_grant),
        .idx   (pick_idx)
    );

    assign grant_ok  = state == S_IDLE && |req && !uart_tx_active;
    assign to_hit    = state == S_WAIT_ACT && !uart_tx_active && cnt == TO_BITS'(ACTIVE_TIMEOUT - 1);
    assign done      = state == S_WAIT_DONE && !uart_tx_active;
    assign owner_inc = owner == OWNER_BITS'(NUM_REQ - 1) ? '0 : owner + OWNER_BITS'(1);
    assign owner_hot = NUM_REQ'(1) << owner;
`ifdef UART_TX_ARB_LOCK_EN
    assign lock_hold = |(req_lock & req & owner_hot);
`else
    logic unused_lock;
    assign unused_lock = ^{req_lock, owner_hot};
    assign lock_hold = 1'b0;
`endif

    // byte of the requester the arbiter would grant this cycle
    always_comb begin
        pick_byte = 8'h00;
        for (int i = 0; i < NUM_REQ; i++)
            if (pick_grant[i]) pick_byte = req_data[8*i +: 8];
    end

    // next state; sync_reset abandons tracking but never aborts the serializer frame
    always_comb begin
        state_nxt = sync_reset ? S_IDLE :
                    state == S_IDLE ? (grant_ok ? S_START : S_IDLE) :
                    state == S_START ? S_WAIT_ACT :
                    state == S_WAIT_ACT ? (uart_tx_active ? S_WAIT_DONE : to_hit ? S_IDLE : S_WAIT_ACT) :
                    state == S_WAIT_DONE ? (uart_tx_active ? S_WAIT_DONE : S_IDLE) : S_IDLE;
    end

    // next values of the registered outputs, pointer and timeout counter
    always_comb begin
        start_nxt = state_nxt == S_START;
        busy_nxt  = state_nxt != S_IDLE;
        ack_nxt   = start_nxt ? pick_grant : '0;
        owner_nxt = sync_reset ? '0 : grant_ok ? pick_idx : owner;
        sbuf_nxt  = sync_reset ? 8'h00 : grant_ok ? pick_byte : uart_SBUF;
        terr_nxt  = !sync_reset && (timeout_err || to_hit);
        ptr_nxt   = sync_reset ? '0 : done ? (lock_hold ? owner : owner_inc) : to_hit ? owner_inc : ptr;
        cnt_nxt   = state == S_WAIT_ACT && !sync_reset ? cnt + TO_BITS'(1) : '0;
    end

    // state, datapath and output registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= S_IDLE;
            ptr           <= '0;
            cnt           <= '0;
            owner         <= '0;
            uart_SBUF     <= 8'h00;
            ack           <= '0;
            busy          <= 1'b0;
            timeout_err   <= 1'b0;
            uart_start_TX <= 1'b0;
        end else begin
            state         <= state_nxt;
            ptr           <= ptr_nxt;
            cnt           <= cnt_nxt;
            owner         <= owner_nxt;
            uart_SBUF     <= sbuf_nxt;
            ack           <= ack_nxt;
            busy          <= busy_nxt;
            timeout_err   <= terr_nxt;
            uart_start_TX <= start_nxt;
        end
    end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: scoreboard bench with a serializer model and requester agents
module tb_uart_tx_arbiter;
    localparam int N = 4;
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic sync_reset = 1'b0;
    logic [N-1:0] req = '0;
    logic [N-1:0] req_lock = '0;
    logic [8*N-1:0] req_data = {8'h3C, 8'hA5, 8'h5A, 8'h11};
    logic [N-1:0] ack;
    logic [2:0] owner;
    logic busy, timeout_err, uart_start_TX;
    logic [7:0] uart_SBUF;
    logic uart_tx_active = 1'b0;
    logic no_active = 1'b0;
    int checks = 0;
    int errors = 0;
    int rem [N] = '{0, 0, 0, 0};
    logic [10:0] exp_q [$];
    logic [10:0] mon_e;
    logic [7:0] hold_sbuf = 8'h00;
    logic hold_on = 1'b0;
    int t;

    always #5 clk = ~clk;

    uart_tx_arbiter #(.NUM_REQ(N), .ACTIVE_TIMEOUT(15)) dut (
        .clk            (clk),
        .reset          (reset),
        .sync_reset     (sync_reset),
        .req            (req),
        .req_data       (req_data),
        .req_lock       (req_lock),
        .ack            (ack),
        .owner          (owner),
        .busy           (busy),
        .timeout_err    (timeout_err),
        .uart_start_TX  (uart_start_TX),
        .uart_SBUF      (uart_SBUF),
        .uart_tx_active (uart_tx_active)
    );

    task automatic chk(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push(int i);
        exp_q.push_back({3'(i), req_data[8*i +: 8]});
    endtask

    task automatic sync_pulse();
        @(posedge clk); #1;
        sync_reset = 1'b1;
        @(posedge clk); #1;
        sync_reset = 1'b0;
    endtask

    task automatic wait_start(string name, output int n);
        n = 0;
        while (!uart_start_TX && n < 10) begin
            @(posedge clk); #1;
            n++;
        end
        chk({name, "_start_seen"}, int'(uart_start_TX), 1);
    endtask

    task automatic wait_active(string name);
        int n = 0;
        while (!uart_tx_active && n < 10) begin
            @(posedge clk); #1;
            n++;
        end
        chk({name, "_active_seen"}, int'(uart_tx_active), 1);
    endtask

    task automatic no_grant_while_active(string name);
        int n = 0;
        while (uart_tx_active && n < 20) begin
            chk({name, "_idle_while_active"}, int'(busy), 0);
            @(posedge clk); #1;
            n++;
        end
    endtask

    task automatic drain(string name);
        int n = 0;
        while ((exp_q.size() != 0 || busy || uart_tx_active) && n < 400) begin
            @(posedge clk); #1;
            n++;
        end
        chk({name, "_drained"}, int'(n < 400), 1);
        chk({name, "_queue_empty"}, exp_q.size(), 0);
    endtask

    // serializer model: active rises the cycle after a start, lasts 11 cycles
    initial begin
        forever begin
            @(negedge clk);
            if (uart_start_TX && !no_active && !reset) begin
                @(posedge clk); #1;
                uart_tx_active = 1'b1;
                repeat (11) @(posedge clk);
                #1 uart_tx_active = 1'b0;
            end
        end
    end

    // requester agents: hold req for rem[i] bytes, dropping req and lock on the last ack
    always @(negedge clk) begin
        for (int i = 0; i < N; i++)
            if (ack[i] && rem[i] > 0) begin
                rem[i]--;
                if (rem[i] == 0) begin
                    req[i] = 1'b0;
                    req_lock[i] = 1'b0;
                end
            end
    end

    // monitor: every start pulse pops the next expected grant
    always @(negedge clk) begin
        if (uart_start_TX) begin
            if (exp_q.size() == 0) chk("unexpected_start", exp_q.size(), 1);
            else begin
                mon_e = exp_q.pop_front();
                chk("owner", int'(owner), int'(mon_e[10:8]));
                chk("sbuf", int'(uart_SBUF), int'(mon_e[7:0]));
                chk("ack", int'(ack), 1 << mon_e[10:8]);
                chk("active_at_start", int'(uart_tx_active), 0);
                hold_sbuf = uart_SBUF;
                hold_on = 1'b1;
            end
        end else begin
            chk("ack_idle", int'(ack), 0);
            if (hold_on && busy) chk("sbuf_stable", int'(uart_SBUF), int'(hold_sbuf));
        end
        if (!busy) hold_on = 1'b0;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("rst_owner", int'(owner), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_start", int'(uart_start_TX), 0);
        chk("rst_sbuf", int'(uart_SBUF), 0);
        chk("rst_terr", int'(timeout_err), 0);
        chk("rst_ack", int'(ack), 0);
        reset = 1'b0;
        // async reset mid-frame
        @(posedge clk); #1;
        push(0);
        rem[0] = 1;
        req[0] = 1'b1;
        wait_active("areset");
        repeat (2) @(posedge clk);
        #2 reset = 1'b1;
        #1;
        chk("areset_owner", int'(owner), 0);
        chk("areset_busy", int'(busy), 0);
        chk("areset_sbuf", int'(uart_SBUF), 0);
        chk("areset_ack", int'(ack), 0);
        chk("areset_start", int'(uart_start_TX), 0);
        push(3);
        rem[3] = 1;
        req[3] = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        no_grant_while_active("areset");
        drain("areset");
        // single request, byte A5 from requester 2
        sync_pulse();
        push(2);
        rem[2] = 1;
        req[2] = 1'b1;
        wait_start("single", t);
        chk("single_latency", int'(t >= 1 && t <= 2), 1);
        drain("single");
        // fairness: all four requesting
        sync_pulse();
        push(0); push(1); push(2); push(3); push(0);
        rem = '{2, 1, 1, 1};
        req = 4'b1111;
        drain("fair");
        // timeout: serializer never goes active
        sync_pulse();
        no_active = 1'b1;
        push(1);
        rem[1] = 1;
        req[1] = 1'b1;
        wait_start("timeout", t);
        repeat (10) @(posedge clk);
        #1;
        chk("timeout_early_terr", int'(timeout_err), 0);
        chk("timeout_early_busy", int'(busy), 1);
        t = 10;
        while (!timeout_err && t < 30) begin
            @(posedge clk); #1;
            t++;
        end
        chk("timeout_cycles", t, 16);
        chk("timeout_terr", int'(timeout_err), 1);
        chk("timeout_idle", int'(busy), 0);
        no_active = 1'b0;
        push(3);
        rem[3] = 1;
        req[3] = 1'b1;
        drain("after_timeout");
        chk("terr_sticky", int'(timeout_err), 1);
        sync_pulse();
        chk("terr_cleared", int'(timeout_err), 0);
        // burst lock on requester 0
`ifdef UART_TX_ARB_LOCK_EN
        push(0); push(0); push(0); push(1); push(1);
`else
        push(0); push(1); push(0); push(1); push(0);
`endif
        rem = '{3, 2, 0, 0};
        req_lock = 4'b0001;
        req = 4'b0011;
        drain("lock");
        // sync_reset while waiting for the frame to finish
        sync_pulse();
        push(2);
        rem[2] = 1;
        req[2] = 1'b1;
        wait_active("sreset");
        repeat (3) @(posedge clk);
        #1;
        sync_reset = 1'b1;
        push(1);
        rem[1] = 1;
        req[1] = 1'b1;
        @(posedge clk); #1;
        sync_reset = 1'b0;
        chk("sreset_busy", int'(busy), 0);
        chk("sreset_owner", int'(owner), 0);
        chk("sreset_sbuf", int'(uart_SBUF), 0);
        no_grant_while_active("sreset");
        drain("sreset");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
